// File: rtl/pattern_blinker.sv
// Multi-channel LED pattern sequencer: each channel plays a PAT_LEN-bit pattern,
// one bit per TICK_DIV clocks, in repeat or one-shot mode, reloadable at runtime.
module pattern_blinker #(
  parameter int CHANNELS = 1,
  parameter int PAT_LEN = 32,
  parameter int TICK_DIV = 1048576,
  parameter logic [PAT_LEN-1:0] DEFAULT_PATTERN = PAT_LEN'(32'b101010001110111011100010101),
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                load_valid_i,
  output logic                load_ready_o,
  input  logic [CHW-1:0]      load_ch_i,
  input  logic [PAT_LEN-1:0]  load_pattern_i,
  input  logic                load_oneshot_i,
  output logic [CHANNELS-1:0] led_o,
  output logic [CHANNELS-1:0] busy_o
);

  localparam int IW = $clog2(PAT_LEN);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(PAT_LEN - 1);
  localparam logic [TW-1:0] TK_LAST = TW'(TICK_DIV - 1);

  logic [PAT_LEN-1:0]  pat_q [CHANNELS];
  logic [PAT_LEN-1:0]  pat_d [CHANNELS];
  logic [IW-1:0]       idx_q [CHANNELS];
  logic [IW-1:0]       idx_d [CHANNELS];
  logic [TW-1:0]       tk_q  [CHANNELS];
  logic [TW-1:0]       tk_d  [CHANNELS];
  logic [CHANNELS-1:0] os_q, os_d;
  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic                ready_q;
  logic                load_fire;

  assign load_fire    = load_valid_i & ready_q;
  assign load_ready_o = ready_q;
  assign led_o        = led_q;
  assign busy_o       = os_q & run_q;

  // Out-of-range channel numbers never match a loop index, so such loads vanish.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      pat_d[c] = pat_q[c];
      idx_d[c] = idx_q[c];
      tk_d[c]  = tk_q[c];
      os_d[c]  = os_q[c];
      run_d[c] = run_q[c];
      led_d[c] = pat_q[c][idx_q[c]] & run_q[c];
      if (load_fire && (load_ch_i == CHW'(c))) begin
        pat_d[c] = load_pattern_i;
        os_d[c]  = load_oneshot_i;
        run_d[c] = 1'b1;
        idx_d[c] = '0;
        tk_d[c]  = '0;
      end else if (enable_i && run_q[c]) begin
        if (tk_q[c] == TK_LAST) begin
          tk_d[c] = '0;
          if (idx_q[c] != IDX_LAST) begin
            idx_d[c] = idx_q[c] + 1'b1;
          end else if (os_q[c]) begin
            run_d[c] = 1'b0;
          end else begin
            idx_d[c] = '0;
          end
        end else begin
          tk_d[c] = tk_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < CHANNELS; c++) begin
        pat_q[c] <= DEFAULT_PATTERN;
        idx_q[c] <= '0;
        tk_q[c]  <= '0;
      end
      os_q    <= '0;
      run_q   <= '1;
      led_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      tk_q    <= tk_d;
      os_q    <= os_d;
      run_q   <= run_d;
      led_q   <= led_d;
      ready_q <= 1'b1;
    end
  end

endmodule
